// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: sequencer for one serial-parallel multiply on a single spm.
// Takes operands over a valid/ready handshake. It clears the spm, then shifts
// the multiplier into spm_y LSB-first. It gathers the serial spm_p stream into
// a 2*size-bit product and returns that product over a valid/ready handshake.
// Build option: define SPM_SEQ_CTRL_SIGNED_EN for two's complement operands
// (the multiplier is sign-extended while it shifts out). Leave it undefined
// for an unsigned product.
module spm_seq_ctrl #(
    parameter int size  = 32,
    parameter int P_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [size-1:0]     a,
    input  logic [size-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*size-1:0]   prod,
    output logic                busy,
    output logic                spm_rst,
    output logic [size-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    localparam int RUN_LEN = 2 * size + P_LAT;
    localparam int CW      = $clog2(RUN_LEN + 1);

    // First and last RUN cycles that capture a product bit, plus the extra
    // cycle in which the completed accumulator is copied into prod.
    localparam logic [CW-1:0] CAP_FIRST = CW'(P_LAT);
    localparam logic [CW-1:0] CAP_LAST  = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] RUN_END   = CW'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [size-1:0]   sreg;
    logic [2*size-1:0] acc;
    logic              fill_bit;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
    // An arithmetic shift keeps replicating b[size-1], which is the sign
    // latched at accept, so y is sign-extended for the upper size cycles.
    assign fill_bit = sreg[size-1];
`else
    assign fill_bit = 1'b0;
`endif

    // Handshake/sequencing FSM with registered outputs and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register here samples pre-edge values regardless of statement order.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            prod      <= '0;
            busy      <= 1'b0;
            spm_rst   <= 1'b0;
            spm_x     <= '0;
            spm_y     <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    spm_rst  <= 1'b1;
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        spm_x    <= a;
                        sreg     <= b;
                        spm_y    <= 1'b0;
                        spm_rst  <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CLR;
                    end
                end

                CLR: begin
                    // spm has been held in clear for this cycle; present b[0] next.
                    spm_rst <= 1'b1;
                    cnt     <= '0;
                    spm_y   <= sreg[0];
                    sreg    <= {fill_bit, sreg[size-1:1]};
                    state   <= RUN;
                end

                RUN: begin
                    spm_y <= sreg[0];
                    sreg  <= {fill_bit, sreg[size-1:1]};
                    if (cnt >= CAP_FIRST && cnt <= CAP_LAST) begin
                        acc <= {spm_p, acc[2*size-1:1]};
                    end
                    if (cnt == RUN_END) begin
                        // acc is complete: publish it and stop driving y.
                        prod      <= acc;
                        out_valid <= 1'b1;
                        spm_y     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed self-checking bench for spm_seq_ctrl (size=8, P_LAT=1) with a
// behavioural serial-parallel multiplier standing in for the spm.
module tb_spm_seq_ctrl;

    localparam int SIZE  = 8;
    localparam int P_LAT = 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE-1:0] prod;
    logic              busy;
    logic              spm_rst;
    logic [SIZE-1:0]   spm_x;
    logic              spm_y;
    logic              spm_p;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    spm_seq_ctrl #(.size(SIZE), .P_LAT(P_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy),
        .spm_rst   (spm_rst),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural spm: adds y_k * x << k to a running sum each clock; bit k is
    // then final and is registered onto spm_p (one cycle of latency).
    logic [2*SIZE-1:0] m_sum;
    logic [2*SIZE-1:0] m_x;
    logic [2*SIZE-1:0] m_nxt;
    int                m_k;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
    assign m_x = {{SIZE{spm_x[SIZE-1]}}, spm_x};
`else
    assign m_x = {{SIZE{1'b0}}, spm_x};
`endif

    always @(posedge clk) begin
        if (!spm_rst) begin
            m_sum <= '0;
            m_k   <= 0;
            spm_p <= 1'b0;
        end else if (m_k < 2 * SIZE) begin
            m_nxt = m_sum + (spm_y ? (m_x << m_k) : '0);
            m_sum <= m_nxt;
            spm_p <= m_nxt[m_k];
            m_k   <= m_k + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair, wait for the product with out_ready=1, then
    // confirm the handshake returns the controller to idle.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [15:0] exp, input string tag);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check({tag, "_ready"}, in_ready, 1);
        a = op_a;
        b = op_b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        busy_ok = (busy === 1'b1) && (in_ready === 1'b0);
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_busy_thru"}, busy_ok, 1);
        check({tag, "_latency"}, lat, 19);
        check({tag, "_prod"}, prod, exp);
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_idle"}, {busy, in_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  pa [4];
    logic [7:0]  pb [4];
    logic [15:0] pe [4];
    int          acc_n;
    int          out_n;
    bit          hold_ok;
    int          wait_n;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_prod", prod, 0);
        check("rst_busy", busy, 0);
        check("rst_spm_rst", spm_rst, 0);
        check("rst_spm_x", spm_x, 0);
        check("rst_spm_y", spm_y, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic multiply
        run_op(8'd3, 8'd5, 16'h000F, "basic");

`ifdef SPM_SEQ_CTRL_SIGNED_EN
        run_op(8'hFD, 8'h05, 16'hFFF1, "signed_neg");
        run_op(8'h80, 8'h80, 16'h4000, "signed_min");
`else
        run_op(8'hFF, 8'hFF, 16'hFE01, "max_unsigned");
`endif

        // Backpressure: product must hold while out_ready is low
        @(negedge clk);
        a = 8'd10;
        b = 8'd12;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_n = 0;
        while (out_valid !== 1'b1 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 8'd7;
                b = 8'd9;
                in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (prod !== 16'd120 || out_valid !== 1'b1 || busy !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("bp_hold", hold_ok, 1);
        check("bp_prod", prod, 16'd120);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {out_valid, busy, in_ready}, 3'b001);
        @(posedge clk);
        #1;
        check("bp_no_stray_accept", busy, 0);
        run_op(8'd7, 8'd9, 16'd63, "bp_after");

        // Reset in RUN at cnt=5
        @(negedge clk);
        a = 8'd50;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_outputs", {in_ready, out_valid, busy, spm_rst, spm_y}, 5'b10000);
        check("mid_rst_prod", prod, 0);
        check("mid_rst_spm_x", spm_x, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'd2, 8'd2, 16'd4, "after_rst");

        // Back-to-back with in_valid held high
        pa = '{8'd1, 8'd13, 8'd100, 8'd0};
        pb = '{8'd1, 8'd11, 8'd50, 8'd77};
        pe = '{16'd1, 16'd143, 16'd5000, 16'd0};
        acc_n = 0;
        out_n = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && out_n < 4; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                check($sformatf("b2b_prod%0d", out_n), prod, pe[out_n]);
                out_n++;
            end
            if (acc_n < 4) begin
                in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    a = pa[acc_n];
                    b = pb[acc_n];
                    acc_n++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc_n, 4);
        check("b2b_products", out_n, 4);
        repeat (3) @(negedge clk);
        check("b2b_idle", {busy, in_ready, out_valid}, 3'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
